// File: rtl/mole_hit_arbiter.sv
// Hit-button front end: synchronise, edge-detect and debounce 16 raw presses,
// queue accepted hits and grant one per cycle in round-robin order with GOOD/BAD/MISS class.
module mole_hit_arbiter #(
  parameter int unsigned N_CELLS     = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCKOUT     = 8
) (
  input  logic               Clk,
  input  logic               Set,
  input  logic               enable,
  input  logic [N_CELLS-1:0] hit_raw,
  input  logic [N_CELLS-1:0] good_mole,
  input  logic [N_CELLS-1:0] bad_mole,
  output logic               grant_valid,
  output logic [N_CELLS-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [1:0]         grant_kind,
  output logic [IDX_W:0]     pending_cnt,
  output logic [7:0]         reject_cnt
);

  localparam int unsigned LK_W = $clog2(LOCKOUT + 1);

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_GOOD = 2'b01,
    KIND_BAD  = 2'b10,
    KIND_MISS = 2'b11
  } kind_e;

  logic [N_CELLS-1:0] r_sync [SYNC_STAGES];
  logic [N_CELLS-1:0] r_hist;
  logic [N_CELLS-1:0] r_pending;
  logic [LK_W-1:0]    r_lock [N_CELLS];
  logic [IDX_W-1:0]   r_ptr;

  logic [N_CELLS-1:0] w_press;
  logic [N_CELLS-1:0] w_lock_zero;
  logic [N_CELLS-1:0] w_accept;
  logic [N_CELLS-1:0] w_reject;
  logic [N_CELLS-1:0] w_sel_onehot;
  logic [N_CELLS-1:0] w_pend_nxt;
  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_j;
  logic [IDX_W-1:0]   w_ptr_nxt;
  kind_e              w_sel_kind;
  logic [IDX_W:0]     w_pend_cnt;
  logic [8:0]         w_rej_sum;
  logic [7:0]         w_rej_nxt;

  always_comb begin
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      w_lock_zero[i] = (r_lock[i] == '0);
    end
    w_press  = r_sync[SYNC_STAGES-1] & ~r_hist;
    w_accept = w_press & {N_CELLS{enable}} & w_lock_zero;
    w_reject = w_press & {N_CELLS{enable}} & ~w_lock_zero;
  end

  // Circular scan starting at r_ptr; the first pending cell found wins.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_j         = '0;
    if (enable) begin
      for (int unsigned k = 0; k < N_CELLS; k++) begin
        w_j = IDX_W'((32'(r_ptr) + k) % N_CELLS);
        if (!w_sel_valid && r_pending[w_j]) begin
          w_sel_valid = 1'b1;
          w_sel_idx   = w_j;
        end
      end
    end
  end

  always_comb begin
    w_sel_onehot = '0;
    w_sel_kind   = KIND_NONE;
    w_ptr_nxt    = r_ptr;
    if (w_sel_valid) begin
      w_sel_onehot = N_CELLS'(1) << w_sel_idx;
      if (good_mole[w_sel_idx])     w_sel_kind = KIND_GOOD;
      else if (bad_mole[w_sel_idx]) w_sel_kind = KIND_BAD;
      else                          w_sel_kind = KIND_MISS;
      w_ptr_nxt = (w_sel_idx == IDX_W'(N_CELLS - 1)) ? '0 : w_sel_idx + 1'b1;
    end
    // Clear-then-set ordering lets a same-cycle accept win over the grant clear.
    w_pend_nxt = enable ? ((r_pending & ~w_sel_onehot) | w_accept) : '0;
    w_pend_cnt = (IDX_W + 1)'($countones(w_pend_nxt));
    w_rej_sum  = 9'(reject_cnt) + 9'($countones(w_reject));
    w_rej_nxt  = (w_rej_sum > 9'd255) ? 8'hFF : w_rej_sum[7:0];
  end

  always_ff @(posedge Clk) begin
    if (Set) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= hit_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (Set)                   r_lock[i] <= '0;
      else if (w_accept[i])      r_lock[i] <= LK_W'(LOCKOUT);
      else if (!w_lock_zero[i])  r_lock[i] <= r_lock[i] - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Set) begin
      r_pending    <= '0;
      r_ptr        <= '0;
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      grant_idx    <= '0;
      grant_kind   <= KIND_NONE;
      pending_cnt  <= '0;
      reject_cnt   <= '0;
    end else begin
      r_pending    <= w_pend_nxt;
      r_ptr        <= w_ptr_nxt;
      grant_valid  <= w_sel_valid;
      grant_onehot <= w_sel_onehot;
      if (w_sel_valid) grant_idx <= w_sel_idx;
      grant_kind   <= w_sel_kind;
      pending_cnt  <= w_pend_cnt;
      reject_cnt   <= w_rej_nxt;
    end
  end

endmodule
